// File: rtl/round_ctrl.sv
// Round sequencer for Cross the Road: debounces start, runs the countdown, tracks lives
// and drives the stopwatch sw_rst/start/finish controls.
`timescale 1ns/1ps
module round_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned TICK_CYCLES     = 100_000_000,
    parameter int unsigned COUNTDOWN_TICKS = 3,
    parameter int unsigned LIVES           = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       hit,
    input  logic       goal,
    output logic       sw_rst,
    output logic       start,
    output logic       finish,
    output logic [2:0] state,
    output logic [1:0] lives_left,
    output logic [1:0] countdown
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNTDOWN = 3'd1,
        PLAY      = 3'd2,
        WIN       = 3'd3,
        LOSE      = 3'd4
    } state_t;

    localparam logic [19:0] DB_LAST   = 20'(DEBOUNCE_CYCLES - 1);
    localparam logic [26:0] TICK_LAST = 27'(TICK_CYCLES - 1);
    localparam logic [1:0]  LIVES_INIT = 2'(LIVES);
    localparam logic [1:0]  CD_INIT    = 2'(COUNTDOWN_TICKS);

    logic [1:0]  btn_sync, hit_sync, goal_sync;
    logic [19:0] db_cnt;
    logic        btn_db, btn_db_q, press;
    logic        hit_q, goal_q, hit_e, goal_e;

    state_t      state_q, state_d;
    logic [26:0] tick_q, tick_d;
    logic [1:0]  lives_q, lives_d, cd_q, cd_d;
    logic        sw_rst_q, sw_rst_d, start_q, start_d, finish_q, finish_d;

    // Debounce: a synced value differing from btn_db must hold for DEBOUNCE_CYCLES samples;
    // any return to the debounced level restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_sync  <= '0;
            hit_sync  <= '0;
            goal_sync <= '0;
            db_cnt    <= '0;
            btn_db    <= 1'b0;
            btn_db_q  <= 1'b0;
            press     <= 1'b0;
            hit_q     <= 1'b0;
            goal_q    <= 1'b0;
            hit_e     <= 1'b0;
            goal_e    <= 1'b0;
        end else begin
            btn_sync  <= {btn_sync[0], btn_start};
            hit_sync  <= {hit_sync[0], hit};
            goal_sync <= {goal_sync[0], goal};
            if (btn_sync[1] == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt <= '0;
                btn_db <= btn_sync[1];
            end else begin
                db_cnt <= db_cnt + 20'd1;
            end
            btn_db_q <= btn_db;
            press    <= btn_db & ~btn_db_q;
            hit_q    <= hit_sync[1];
            goal_q   <= goal_sync[1];
            hit_e    <= hit_sync[1] & ~hit_q;
            goal_e   <= goal_sync[1] & ~goal_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            lives_q  <= LIVES_INIT;
            cd_q     <= '0;
            sw_rst_q <= 1'b0;
            start_q  <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            lives_q  <= lives_d;
            cd_q     <= cd_d;
            sw_rst_q <= sw_rst_d;
            start_q  <= start_d;
            finish_q <= finish_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        lives_d  = lives_q;
        cd_d     = cd_q;
        sw_rst_d = 1'b0;
        start_d  = 1'b0;
        case (state_q)
            IDLE, WIN, LOSE: begin
                if (press) begin
                    sw_rst_d = 1'b1;
                    lives_d  = LIVES_INIT;
                    cd_d     = CD_INIT;
                    tick_d   = '0;
                    state_d  = COUNTDOWN;
                end
            end
            COUNTDOWN: begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (cd_q == 2'd1) begin
                        cd_d    = '0;
                        start_d = 1'b1;
                        state_d = PLAY;
                    end else begin
                        cd_d = cd_q - 2'd1;
                    end
                end else begin
                    tick_d = tick_q + 27'd1;
                end
            end
            PLAY: begin
                if (goal_e) begin
                    state_d = WIN;
                end else if (hit_e) begin
                    if (lives_q > 2'd1) begin
                        lives_d = lives_q - 2'd1;
                    end else begin
                        lives_d = '0;
                        state_d = LOSE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        finish_d = (state_d == WIN) || (state_d == LOSE);
    end

    assign sw_rst     = sw_rst_q;
    assign start      = start_q;
    assign finish     = finish_q;
    assign state      = state_q;
    assign lives_left = lives_q;
    assign countdown  = cd_q;

endmodule

// File: tb/tb_round_ctrl.sv
// Directed bench for round_ctrl with short debounce/tick periods; expected values hand-derived.
`timescale 1ns/1ps
module tb_round_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_start, hit, goal;
    logic       sw_rst, start, finish;
    logic [2:0] state;
    logic [1:0] lives_left, countdown;

    int n_cmp = 0;
    int n_bad = 0;
    int sw_cnt = 0;
    int st_cnt = 0;
    int both_cnt = 0;
    int sw_base = 0;

    round_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .TICK_CYCLES(10),
        .COUNTDOWN_TICKS(3),
        .LIVES(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_start(btn_start),
        .hit(hit),
        .goal(goal),
        .sw_rst(sw_rst),
        .start(start),
        .finish(finish),
        .state(state),
        .lives_left(lives_left),
        .countdown(countdown)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sw_rst) sw_cnt <= sw_cnt + 1;
        if (start) st_cnt <= st_cnt + 1;
        if (sw_rst && start) both_cnt <= both_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Raises btn_start and returns the number of negedges until COUNTDOWN (0 = timeout).
    task automatic do_press(output int k);
        k = 0;
        btn_start = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (state == 3'd1) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic wait_play(output int k);
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (state == 3'd2) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; btn_start = 1'b0; hit = 1'b0; goal = 1'b0;
        step(3);
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state got %0d exp 0", state); end
        n_cmp++; if (lives_left !== 2'd3) begin n_bad++; $display("FAIL reset_lives got %0d exp 3", lives_left); end
        n_cmp++; if (countdown !== 2'd0) begin n_bad++; $display("FAIL reset_countdown got %0d exp 0", countdown); end
        n_cmp++; if ({sw_rst, start, finish} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses got %b exp 000", {sw_rst, start, finish}); end
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_press_debounce;
        int k;
        sw_base = sw_cnt;
        btn_start = 1'b1; step(3);
        btn_start = 1'b0; step(4);
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL glitch_state got %0d exp 0", state); end
        n_cmp++; if (sw_cnt != sw_base) begin n_bad++; $display("FAIL glitch_swrst got %0d exp %0d", sw_cnt, sw_base); end
        do_press(k);
        n_cmp++; if (k != 8) begin n_bad++; $display("FAIL press_latency got %0d exp 8", k); end
        n_cmp++; if (sw_rst !== 1'b1) begin n_bad++; $display("FAIL press_swrst got %b exp 1", sw_rst); end
        n_cmp++; if (countdown !== 2'd3) begin n_bad++; $display("FAIL press_countdown got %0d exp 3", countdown); end
    endtask

    task automatic test_countdown;
        int st0;
        logic [1:0] exp_cd;
        st0 = st_cnt;
        for (int i = 1; i <= 31; i++) begin
            @(negedge clk);
            if (i == 1) btn_start = 1'b0;
            exp_cd = (i < 10) ? 2'd3 : (i < 20) ? 2'd2 : (i < 30) ? 2'd1 : 2'd0;
            if (i == 9 || i == 10 || i == 19 || i == 20 || i == 29 || i == 30) begin
                n_cmp++; if (countdown !== exp_cd) begin n_bad++; $display("FAIL countdown_i%0d got %0d exp %0d", i, countdown, exp_cd); end
            end
            if (i == 29) begin
                n_cmp++; if ({state, start} !== {3'd1, 1'b0}) begin n_bad++; $display("FAIL pre_play got state %0d start %b exp 1/0", state, start); end
            end
            if (i == 30) begin
                n_cmp++; if ({state, start, sw_rst} !== {3'd2, 1'b1, 1'b0}) begin n_bad++; $display("FAIL play_entry got state %0d start %b sw_rst %b exp 2/1/0", state, start, sw_rst); end
            end
            if (i == 31) begin
                n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL start_width got %b exp 0", start); end
            end
        end
        n_cmp++; if (st_cnt - st0 != 1) begin n_bad++; $display("FAIL start_count got %0d exp 1", st_cnt - st0); end
        n_cmp++; if (sw_cnt - sw_base != 1) begin n_bad++; $display("FAIL swrst_count got %0d exp 1", sw_cnt - sw_base); end
    endtask

    task automatic test_goal_win;
        int k;
        goal = 1'b1;
        step(3);
        n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL goal_early got %0d exp 2", state); end
        step(1);
        n_cmp++; if ({state, finish, lives_left} !== {3'd3, 1'b1, 2'd3}) begin n_bad++; $display("FAIL goal_win got state %0d finish %b lives %0d exp 3/1/3", state, finish, lives_left); end
        step(3);
        n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL goal_hold got %0d exp 3", state); end
        do_press(k);
        n_cmp++; if (k != 8) begin n_bad++; $display("FAIL win_press_latency got %0d exp 8", k); end
        n_cmp++; if ({finish, sw_rst} !== 2'b01) begin n_bad++; $display("FAIL win_restart got finish %b sw_rst %b exp 0/1", finish, sw_rst); end
        goal = 1'b0; btn_start = 1'b0;
        wait_play(k);
        n_cmp++; if (k != 30) begin n_bad++; $display("FAIL win_to_play got %0d exp 30", k); end
    endtask

    task automatic test_hits;
        hit = 1'b1; step(4);
        n_cmp++; if ({state, lives_left} !== {3'd2, 2'd2}) begin n_bad++; $display("FAIL hit1 got state %0d lives %0d exp 2/2", state, lives_left); end
        step(6);
        n_cmp++; if (lives_left !== 2'd2) begin n_bad++; $display("FAIL hit_held got %0d exp 2", lives_left); end
        hit = 1'b0; step(3);
        hit = 1'b1; step(4);
        n_cmp++; if (lives_left !== 2'd1) begin n_bad++; $display("FAIL hit2 got %0d exp 1", lives_left); end
        hit = 1'b0; step(3);
        hit = 1'b1; step(3);
        n_cmp++; if ({state, lives_left} !== {3'd2, 2'd1}) begin n_bad++; $display("FAIL hit3_early got state %0d lives %0d exp 2/1", state, lives_left); end
        step(1);
        n_cmp++; if ({state, finish, lives_left} !== {3'd4, 1'b1, 2'd0}) begin n_bad++; $display("FAIL hit3_lose got state %0d finish %b lives %0d exp 4/1/0", state, finish, lives_left); end
        hit = 1'b0; step(3);
    endtask

    task automatic test_simultaneous;
        int k;
        do_press(k);
        n_cmp++; if ({k == 8, finish, lives_left} !== {1'b1, 1'b0, 2'd3}) begin n_bad++; $display("FAIL lose_restart got k %0d finish %b lives %0d exp 8/0/3", k, finish, lives_left); end
        btn_start = 1'b0;
        wait_play(k);
        for (int h = 0; h < 2; h++) begin
            hit = 1'b1; step(4);
            hit = 1'b0; step(3);
        end
        n_cmp++; if ({state, lives_left} !== {3'd2, 2'd1}) begin n_bad++; $display("FAIL pre_simul got state %0d lives %0d exp 2/1", state, lives_left); end
        hit = 1'b1; goal = 1'b1; step(4);
        n_cmp++; if ({state, finish, lives_left} !== {3'd3, 1'b1, 2'd1}) begin n_bad++; $display("FAIL simul_goal_prio got state %0d finish %b lives %0d exp 3/1/1", state, finish, lives_left); end
        hit = 1'b0; goal = 1'b0; step(3);
    endtask

    task automatic test_ignore_and_reset;
        int k;
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({state, finish, lives_left} !== {3'd0, 1'b0, 2'd3}) begin n_bad++; $display("FAIL async_rst_win got state %0d finish %b lives %0d exp 0/0/3", state, finish, lives_left); end
        @(negedge clk) rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            hit = i[0]; goal = ~i[0];
            step(1);
        end
        hit = 1'b0; goal = 1'b0; step(4);
        n_cmp++; if ({state, lives_left, countdown, sw_rst} !== {3'd0, 2'd3, 2'd0, 1'b0}) begin n_bad++; $display("FAIL idle_ignore got state %0d lives %0d cd %0d sw_rst %b exp 0/3/0/0", state, lives_left, countdown, sw_rst); end
        do_press(k);
        btn_start = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            hit = (i % 2 == 1); goal = (i % 3 == 0);
            @(negedge clk);
        end
        hit = 1'b0; goal = 1'b0;
        n_cmp++; if ({state, countdown, lives_left} !== {3'd1, 2'd2, 2'd3}) begin n_bad++; $display("FAIL countdown_ignore got state %0d cd %0d lives %0d exp 1/2/3", state, countdown, lives_left); end
        wait_play(k);
        hit = 1'b1; step(4);
        n_cmp++; if ({state, lives_left} !== {3'd2, 2'd2}) begin n_bad++; $display("FAIL pre_rst_play got state %0d lives %0d exp 2/2", state, lives_left); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({state, lives_left, countdown, sw_rst, start, finish} !== {3'd0, 2'd3, 2'd0, 3'b000}) begin n_bad++; $display("FAIL async_rst_play got state %0d lives %0d cd %0d pulses %b exp 0/3/0/000", state, lives_left, countdown, {sw_rst, start, finish}); end
        hit = 1'b0;
        @(negedge clk) rst = 1'b0;
        step(2);
        n_cmp++; if (both_cnt != 0) begin n_bad++; $display("FAIL swrst_start_overlap got %0d exp 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_press_debounce();
        test_countdown();
        test_goal_win();
        test_hits();
        test_simultaneous();
        test_ignore_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
